mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the ARM pipeline, between the execute stage and wb_stage.
- Takes execute-stage results and performs data-memory loads and stores over a req/ack bus.
- Drives the MEM/WB pipeline register that feeds wb_stage: PC, write-back enable, memory-read enable, ALU result, destination, load data.
- Stalls upstream while a bus access is outstanding. Handles misaligned addresses and bus timeout.

Parameters:
- DATA_WIDTH, 32, width of data path, PC and address.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles without i_Mem_Ack before the access is aborted. Range 2..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
- i_Valid  in  1  execute-stage slot holds a real instruction.
- i_Flush  in  1  discard the instruction presented this cycle.
- i_Pc  in  DATA_WIDTH  PC of instruction.
- i_Sig_Write_Back_Enable  in  1  instruction writes a register.
- i_Sig_Memory_Read_Enable  in  1  load.
- i_Sig_Memory_Write_Enable  in  1  store.
- i_ALU_Result  in  DATA_WIDTH  ALU result; memory address for loads/stores.
- i_Store_Value  in  DATA_WIDTH  store data.
- i_Destination  in  4  destination register.
- o_Stall  out  1  upstream must hold its outputs this cycle.
- o_Mem_Req, o_Mem_We  out  1  bus request and write strobe.
- o_Mem_Addr, o_Mem_Wdata  out  DATA_WIDTH  bus address and write data.
- i_Mem_Ack  in  1  bus completes the access this cycle.
- i_Mem_Rdata  in  DATA_WIDTH  read data, valid when i_Mem_Ack=1.
- o_Valid  out  1  MEM/WB slot holds a real instruction.
- o_Pc, o_ALU_Result, o_Data_Memory  out  DATA_WIDTH  MEM/WB register fields.
- o_Sig_Write_Back_Enable, o_Sig_Memory_Read_Enable  out  1  MEM/WB control fields.
- o_Destination  out  4  MEM/WB destination.
- o_Align_Fault, o_Bus_Error  out  1  one-cycle fault pulses.

Behaviour:
- Reset (reset==0 at edge):
  - State goes to IDLE; timeout counter clears.
  - Every registered output goes to 0, including o_Mem_Req.
  - Reset while BUSY abandons the access with no fault pulse.
- Accepted instruction (IDLE): i_Valid & ~i_Flush.
- Memory op: read | write. If both are set, it is treated as a store and o_Sig_Memory_Read_Enable=0.
- Non-memory op in IDLE:
  - MEM/WB loads at next edge with o_Valid=1, o_Data_Memory=0.
  - Latency 1 cycle; o_Stall=0.
- Not accepted, or flushed, in IDLE: MEM/WB loads a bubble (o_Valid=0, o_Sig_Write_Back_Enable=0, other fields 0).
- Misaligned memory op (i_ALU_Result[1:0]!=0):
  - No bus request is issued.
  - Next edge: MEM/WB bubble with o_Pc captured, and o_Align_Fault=1 for one cycle.
- Aligned memory op in IDLE:
  - Control, address and store data are captured into request registers; state goes to BUSY.
  - MEM/WB loads a bubble.
  - o_Stall=0 in the capture cycle.
- BUSY:
  - o_Mem_Req=1; o_Mem_We, o_Mem_Addr, o_Mem_Wdata come from the request registers and are stable for the whole of BUSY.
  - o_Stall=1 for every BUSY cycle, including the ack cycle. The input instruction is consumed only after returning to IDLE.
  - i_Flush is ignored in BUSY; the in-flight access is older and committed.
  - MEM/WB holds a bubble each BUSY edge without ack.
- i_Mem_Ack=1 in BUSY:
  - MEM/WB loads the captured fields with o_Valid=1.
  - o_Data_Memory = i_Mem_Rdata for a load, 0 for a store.
  - State goes to IDLE; o_Mem_Req=0 next cycle.
  - Minimum memory-op latency: 2 edges from presentation to o_Valid.
- Timeout:
  - The counter increments each BUSY cycle without ack.
  - On the edge where the counter equals TIMEOUT_CYCLES-1 with no ack: access is aborted, MEM/WB loads a bubble, o_Bus_Error pulses for 1 cycle, state goes to IDLE.
  - Ack in that same cycle wins: normal completion, no error.
- Counter clears on entering BUSY.
- Outputs are never X after reset; unused fields are driven to 0.

Decomposition:
- pipeline_pkg holds:
  - mem_state_t enum (IDLE, BUSY);
  - DATA_WIDTH default;
  - REG_ADDR_WIDTH=4.
- Sub-module mem_req_ctrl: FSM, timeout counter, o_Stall/o_Mem_Req/o_Bus_Error generation.
- mem_stage holds the request registers, alignment check and the MEM/WB register.

Test Plan:
- ALU op: i_Pc=0x1000, WB=1, i_ALU_Result=0xABCD1234, dest=1 -> next edge o_Valid=1, o_ALU_Result=0xABCD1234, o_Data_Memory=0, o_Stall never 1.
- Load, ack on 2nd BUSY cycle: addr 0x2000, i_Mem_Rdata=0x55667788 -> o_Mem_Req high 2 cycles with o_Mem_Addr=0x2000, o_Stall high 2 cycles, then o_Valid=1, o_Sig_Memory_Read_Enable=1, o_Data_Memory=0x55667788.
- Store: addr 0x2004, i_Store_Value=0xEEFF0011, ack in 1st BUSY cycle -> o_Mem_We=1, o_Mem_Wdata=0xEEFF0011 for one cycle, o_Data_Memory=0; the following held instruction completes one cycle after o_Stall drops.
- Misaligned load at 0x2002 -> o_Mem_Req stays 0, o_Align_Fault=1 for one cycle, o_Valid=0, o_Sig_Write_Back_Enable=0.
- Timeout, TIMEOUT_CYCLES=4, no ack -> o_Mem_Req high 4 cycles, o_Bus_Error pulse, bubble; a repeat run with ack in the 4th cycle gives normal completion and no error.
- reset=0 mid-BUSY -> next cycle all outputs 0, o_Mem_Req=0, state IDLE; i_Flush=1 with a valid load in IDLE -> no request, bubble.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and widths for the memory-access stage and its controller.
package pipeline_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// Bus request controller: IDLE/BUSY sequencing, ack timeout and bus-error pulse.
module mem_req_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic mem_ack_i,
    output logic busy_o,
    output logic done_o,
    output logic stall_o,
    output logic mem_req_o,
    output logic bus_error_o
);
    import pipeline_pkg::*;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       bus_error_q, bus_error_d;

    // Next state, wait counter and error pulse; an ack on the last allowed cycle still completes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = BUSY;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = 8'd0;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Controller state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign busy_o      = (state_q == BUSY);
    assign done_o      = busy_o & mem_ack_i;
    assign stall_o     = busy_o;
    assign mem_req_o   = busy_o;
    assign bus_error_o = bus_error_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: captures loads/stores into request registers,
// runs them over the req/ack bus and fills the MEM/WB register.
module mem_stage #(
    parameter int DATA_WIDTH     = pipeline_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Valid,
    input  logic                  i_Flush,
    input  logic [DATA_WIDTH-1:0] i_Pc,
    input  logic                  i_Sig_Write_Back_Enable,
    input  logic                  i_Sig_Memory_Read_Enable,
    input  logic                  i_Sig_Memory_Write_Enable,
    input  logic [DATA_WIDTH-1:0] i_ALU_Result,
    input  logic [DATA_WIDTH-1:0] i_Store_Value,
    input  logic [3:0]            i_Destination,
    output logic                  o_Stall,
    output logic                  o_Mem_Req,
    output logic                  o_Mem_We,
    output logic [DATA_WIDTH-1:0] o_Mem_Addr,
    output logic [DATA_WIDTH-1:0] o_Mem_Wdata,
    input  logic                  i_Mem_Ack,
    input  logic [DATA_WIDTH-1:0] i_Mem_Rdata,
    output logic                  o_Valid,
    output logic [DATA_WIDTH-1:0] o_Pc,
    output logic [DATA_WIDTH-1:0] o_ALU_Result,
    output logic [DATA_WIDTH-1:0] o_Data_Memory,
    output logic                  o_Sig_Write_Back_Enable,
    output logic                  o_Sig_Memory_Read_Enable,
    output logic [3:0]            o_Destination,
    output logic                  o_Align_Fault,
    output logic                  o_Bus_Error
);
    import pipeline_pkg::*;

    logic busy_s, done_s, accept_s, is_mem_s, aligned_s, start_s;

    logic [DATA_WIDTH-1:0]     req_pc_q, req_pc_d, req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
    logic                      req_wb_q, req_wb_d, req_rd_q, req_rd_d, req_we_q, req_we_d;
    logic [REG_ADDR_WIDTH-1:0] req_dest_q, req_dest_d;

    logic                      valid_q, valid_d, wb_q, wb_d, rd_q, rd_d, align_q, align_d;
    logic [DATA_WIDTH-1:0]     pc_q, pc_d, alu_q, alu_d, data_q, data_d;
    logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;

    mem_req_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_s),
        .mem_ack_i  (i_Mem_Ack),
        .busy_o     (busy_s),
        .done_o     (done_s),
        .stall_o    (o_Stall),
        .mem_req_o  (o_Mem_Req),
        .bus_error_o(o_Bus_Error)
    );

    assign accept_s  = i_Valid & ~i_Flush & ~busy_s;
    assign is_mem_s  = i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable;
    assign aligned_s = is_word_aligned(i_ALU_Result[1:0]);
    assign start_s   = accept_s & is_mem_s & aligned_s;

    // Request registers; a store wins when both read and write are set.
    always_comb begin
        req_pc_d    = req_pc_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wb_d    = req_wb_q;
        req_rd_d    = req_rd_q;
        req_we_d    = req_we_q;
        req_dest_d  = req_dest_q;
        if (start_s) begin
            req_pc_d    = i_Pc;
            req_addr_d  = i_ALU_Result;
            req_wdata_d = i_Store_Value;
            req_wb_d    = i_Sig_Write_Back_Enable;
            req_rd_d    = i_Sig_Memory_Read_Enable & ~i_Sig_Memory_Write_Enable;
            req_we_d    = i_Sig_Memory_Write_Enable;
            req_dest_d  = i_Destination;
        end else begin
            req_pc_d = req_pc_q;
        end
    end

    // MEM/WB next value: a bubble unless an ALU op is accepted or a bus access completes.
    always_comb begin
        valid_d = 1'b0;
        pc_d    = '0;
        wb_d    = 1'b0;
        rd_d    = 1'b0;
        alu_d   = '0;
        dest_d  = 4'd0;
        data_d  = '0;
        align_d = 1'b0;
        if (busy_s) begin
            if (done_s) begin
                valid_d = 1'b1;
                pc_d    = req_pc_q;
                wb_d    = req_wb_q;
                rd_d    = req_rd_q;
                alu_d   = req_addr_q;
                dest_d  = req_dest_q;
                data_d  = req_rd_q ? i_Mem_Rdata : '0;
            end else begin
                valid_d = 1'b0;
            end
        end else if (accept_s) begin
            if (!is_mem_s) begin
                valid_d = 1'b1;
                pc_d    = i_Pc;
                wb_d    = i_Sig_Write_Back_Enable;
                alu_d   = i_ALU_Result;
                dest_d  = i_Destination;
            end else if (!aligned_s) begin
                pc_d    = i_Pc;
                align_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Request and MEM/WB registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_pc_q    <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wb_q    <= 1'b0;
            req_rd_q    <= 1'b0;
            req_we_q    <= 1'b0;
            req_dest_q  <= 4'd0;
            valid_q     <= 1'b0;
            pc_q        <= '0;
            wb_q        <= 1'b0;
            rd_q        <= 1'b0;
            alu_q       <= '0;
            dest_q      <= 4'd0;
            data_q      <= '0;
            align_q     <= 1'b0;
        end else begin
            req_pc_q    <= req_pc_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wb_q    <= req_wb_d;
            req_rd_q    <= req_rd_d;
            req_we_q    <= req_we_d;
            req_dest_q  <= req_dest_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            wb_q        <= wb_d;
            rd_q        <= rd_d;
            alu_q       <= alu_d;
            dest_q      <= dest_d;
            data_q      <= data_d;
            align_q     <= align_d;
        end
    end

    assign o_Mem_We    = busy_s & req_we_q;
    assign o_Mem_Addr  = busy_s ? req_addr_q  : '0;
    assign o_Mem_Wdata = busy_s ? req_wdata_q : '0;

    assign o_Valid                  = valid_q;
    assign o_Pc                     = pc_q;
    assign o_Sig_Write_Back_Enable  = wb_q;
    assign o_Sig_Memory_Read_Enable = rd_q;
    assign o_ALU_Result             = alu_q;
    assign o_Destination            = dest_q;
    assign o_Data_Memory            = data_q;
    assign o_Align_Fault            = align_q;

endmodule
